// File: rtl/mem_port_arbiter.sv
// Two-port (instruction/data) arbiter onto one registered memory port.
// Optional macro ARB_FAIR_EN adds a starvation counter that forces an instruction grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [BE_W-1:0]     m_be_q, m_be_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                busy_q, busy_d;
    logic                force_i_s;
    logic                grant_i_s;
    logic                grant_d_s;

`ifdef ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0]    starve_q, starve_d;

    // Instruction grant is forced once data has won STARVE_MAX times while fetch waited.
    always_comb begin
        force_i_s = i_req && (starve_q == CNT_W'(STARVE_MAX));
    end

    // Starvation counter next state: cleared by a fetch grant, bumped by a contested data grant.
    always_comb begin
        starve_d = starve_q;
        if (grant_i_s) begin
            starve_d = {CNT_W{1'b0}};
        end else if (grant_d_s && i_req) begin
            starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= {CNT_W{1'b0}};
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Fixed priority: data always wins a tie.
    always_comb begin
        force_i_s = 1'b0;
    end
`endif

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !force_i_s) begin
                    grant_d_s = 1'b1;
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_be_d    = d_be;
                end else if (i_req) begin
                    grant_i_s = 1'b1;
                    state_d   = BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_be_d    = {BE_W{1'b1}};
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_I: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    i_ack_d   = 1'b1;
                    i_rdata_d = m_rdata;
                end else begin
                    state_d = BUSY_I;
                end
            end
            BUSY_D: begin
                if (m_ready) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    d_ack_d = 1'b1;
                    // Stores leave the last loaded word visible.
                    if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    state_d = BUSY_D;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= {ADDR_W{1'b0}};
            m_wdata_q <= {DATA_W{1'b0}};
            m_be_q    <= {BE_W{1'b0}};
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters, one per line: ADDR_W, 32, address width; DATA_W, 32, data width; STARVE_MAX, 4, consecutive data grants before a forced instruction grant (ARB_FAIR_EN only).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have instruction-port ports: i_req in 1 (fetch request); i_addr in ADDR_W; i_ack out 1 (one-cycle completion pulse); i_rdata out DATA_W (fetched word).
REQ-005 SHALL have data-port ports: d_req in 1; d_we in 1 (1 = store); d_addr in ADDR_W; d_wdata in DATA_W; d_be in DATA_W/8 (byte enables); d_ack out 1; d_rdata out DATA_W.
REQ-006 SHALL have memory-port ports: m_req out 1; m_we out 1; m_addr out ADDR_W; m_wdata out DATA_W; m_be out DATA_W/8; m_ready in 1 (transfer done, m_rdata valid that cycle); m_rdata in DATA_W.
REQ-007 SHALL have status port busy, out, 1: high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-009 IDLE: d_req high -> latch d_* fields, go to BUSY_D; else i_req high -> latch i_addr, go to BUSY_I; else stay (data beats instruction on a tie without ARB_FAIR_EN).
REQ-010 m_req, m_we, m_addr, m_wdata, m_be SHALL be registered; m_req rises the cycle after the grant decision and holds with all fields stable until m_ready is sampled high.
REQ-011 In BUSY_I, m_we SHALL be 0 and m_be all ones; m_wdata SHALL hold its previous value.
REQ-012 On m_ready high in BUSY_x: capture m_rdata into x_rdata, pulse x_ack for exactly one following cycle, drop m_req the same following cycle, return to IDLE.
REQ-013 Minimum latency: request sampled cycle N -> m_req cycle N+1 -> with m_ready in N+1, ack in N+2; one IDLE cycle SHALL separate back-to-back transactions.
REQ-014 x_rdata SHALL hold its last captured value until the next capture for that port; stores SHALL leave d_rdata unchanged.
REQ-015 Requesters hold x_req and fields until x_ack; a request dropped mid-transaction SHALL still complete and still produce its ack.
REQ-016 m_ready sampled while IDLE SHALL be ignored.
REQ-017 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-018 rstn low SHALL immediately force state IDLE and m_req, m_we, i_ack, d_ack, busy to 0; m_addr, m_wdata, i_rdata, d_rdata to 0; m_be to 0; starvation counter to 0.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no ack; first grant is possible in the first clock edge after rstn rises.

Configuration
REQ-020 Macro ARB_FAIR_EN: when defined, a counter SHALL count consecutive data grants made while i_req was high, clear on any instruction grant, and when it equals STARVE_MAX the next IDLE decision with i_req high SHALL grant instruction regardless of d_req.
REQ-021 When ARB_FAIR_EN is undefined, no counter SHALL exist and REQ-009 fixed priority SHALL apply unconditionally.

Verification
REQ-022 i_req=1, i_addr=0x00000010, m_ready high on first m_req cycle, m_rdata=0x00500093 -> m_req one cycle, i_ack pulse one cycle later, i_rdata=0x00500093.
REQ-023 i_req and d_req rise together, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0xF -> data served first (m_we=1, m_addr=0x40), then one IDLE cycle, then fetch; d_rdata unchanged.
REQ-024 d_req load, m_ready delayed 3 cycles -> m_addr/m_be stable 4 cycles, d_ack exactly one cycle after m_ready, busy high 4 cycles.
REQ-025 rstn pulsed low during BUSY_D before m_ready -> m_req 0 immediately, no d_ack, all outputs at reset values.
REQ-026 ARB_FAIR_EN, STARVE_MAX=4, d_req and i_req held high, m_ready always 1 -> grant order D,D,D,D,I,D,D,D,D,I; without macro -> only D grants.
